// File: rtl/axi_rd_arbiter_if.sv
// Signal bundle between the read arbiter, its two requesters (inst, data) and the AXI AR/R channel.
// Every valid/ready pair transfers exactly when both are high at a rising aclk edge; the source holds valid and payload stable until then.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req_valid;
  logic              inst_req_ready;
  logic [ADDR_W-1:0] inst_req_addr;
  logic [7:0]        inst_req_len;
  logic [2:0]        inst_req_size;
  logic              inst_resp_valid;
  logic              inst_resp_ready;
  logic [DATA_W-1:0] inst_resp_data;
  logic              inst_resp_last;
  logic              inst_resp_err;

  logic              data_req_valid;
  logic              data_req_ready;
  logic [ADDR_W-1:0] data_req_addr;
  logic [7:0]        data_req_len;
  logic [2:0]        data_req_size;
  logic              data_resp_valid;
  logic              data_resp_ready;
  logic [DATA_W-1:0] data_resp_data;
  logic              data_resp_last;
  logic              data_resp_err;

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    input  inst_req_valid, inst_req_addr, inst_req_len, inst_req_size, inst_resp_ready,
    output inst_req_ready, inst_resp_valid, inst_resp_data, inst_resp_last, inst_resp_err,
    input  data_req_valid, data_req_addr, data_req_len, data_req_size, data_resp_ready,
    output data_req_ready, data_resp_valid, data_resp_data, data_resp_last, data_resp_err,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_req_valid, inst_req_addr, inst_req_len, inst_req_size, inst_resp_ready,
    input  inst_req_ready, inst_resp_valid, inst_resp_data, inst_resp_last, inst_resp_err,
    output data_req_valid, data_req_addr, data_req_len, data_req_size, data_resp_ready,
    input  data_req_ready, data_resp_valid, data_resp_data, data_resp_last, data_resp_err,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter (inst fetch / dcache miss), one outstanding burst at a time.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority over inst.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_rd_arbiter_if.master bus,
  output logic [1:0]       dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic              any_req;
  logic              win;
  logic              rready_c;
  logic              unused_r;

  assign any_req = bus.inst_req_valid | bus.data_req_valid;

`ifdef ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // Reset value 0 marks inst as last served, so data takes the first tie.
  assign win = (bus.inst_req_valid && bus.data_req_valid) ? ~last_owner_q : bus.data_req_valid;

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && any_req) last_owner_d = win;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) last_owner_q <= 1'b0;
    else          last_owner_q <= last_owner_d;
  end
`else
  assign win = bus.data_req_valid;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    owner_d              = owner_q;
    addr_d               = addr_q;
    len_d                = len_q;
    size_d               = size_q;
    rready_c             = 1'b0;
    bus.arvalid          = 1'b0;
    bus.inst_req_ready   = 1'b0;
    bus.data_req_ready   = 1'b0;
    bus.inst_resp_valid  = 1'b0;
    bus.data_resp_valid  = 1'b0;
    bus.inst_resp_last   = 1'b0;
    bus.data_resp_last   = 1'b0;
    bus.inst_resp_err    = 1'b0;
    bus.data_resp_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = win;
          addr_d  = win ? bus.data_req_addr : bus.inst_req_addr;
          len_d   = win ? bus.data_req_len  : bus.inst_req_len;
          size_d  = win ? bus.data_req_size : bus.inst_req_size;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) begin
          bus.inst_req_ready = ~owner_q;
          bus.data_req_ready = owner_q;
          state_d            = DATA;
        end
      end
      DATA: begin
        // R beats pass straight through to the registered owner; the other side stays quiet.
        rready_c            = owner_q ? bus.data_resp_ready : bus.inst_resp_ready;
        bus.inst_resp_valid = ~owner_q & bus.rvalid;
        bus.data_resp_valid = owner_q & bus.rvalid;
        bus.inst_resp_last  = ~owner_q & bus.rlast;
        bus.data_resp_last  = owner_q & bus.rlast;
        bus.inst_resp_err   = ~owner_q & bus.rresp[1];
        bus.data_resp_err   = owner_q & bus.rresp[1];
        if (bus.rvalid && rready_c && bus.rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rready         = rready_c;
  assign bus.inst_resp_data = bus.rdata;
  assign bus.data_resp_data = bus.rdata;

  assign bus.arid    = {3'b000, owner_q};
  assign bus.araddr  = addr_q;
  assign bus.arlen   = len_q;
  assign bus.arsize  = size_q;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;

  assign dbg_state_o = state_q;

  // Routing relies on the registered owner, so rid and rresp[0] carry nothing we need.
  assign unused_r = ^{bus.rid, bus.rresp[0]};
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master AXI read-channel arbiter that shares the core's single AXI AR/R port between the instruction-fetch and data-cache miss engines. Each requester presents a simple valid/ready burst request. The arbiter grants one request, drives the AR channel, and steers the returning R beats to the owner. It sits between the cache refill logic and the top-level AXI pins of `mycpu_top`, and supports one outstanding read transaction at a time.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, R data width.
- `aclk`  in  1  clock
- `aresetn`  in  1  asynchronous active-low reset
- `inst_req_valid` / `data_req_valid`  in  1  requester has a read burst pending
- `inst_req_ready` / `data_req_ready`  out  1  request accepted (one-cycle pulse)
- `inst_req_addr` / `data_req_addr`  in  ADDR_W  burst start address
- `inst_req_len` / `data_req_len`  in  8  AXI len (beats−1)
- `inst_req_size` / `data_req_size`  in  3  AXI size
- `inst_resp_valid` / `data_resp_valid`  out  1  beat valid for this requester
- `inst_resp_ready` / `data_resp_ready`  in  1  requester accepts beat
- `inst_resp_data` / `data_resp_data`  out  DATA_W  beat data (shared bus `rdata`)
- `inst_resp_last` / `data_resp_last`  out  1  final beat
- `inst_resp_err` / `data_resp_err`  out  1  `rresp` != OKAY on this beat
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3, `arvalid` out 1, `arready` in 1
- `rid` in 4, `rdata` in DATA_W, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1

## Operation
- State machine with three states: IDLE, ADDR and DATA.
- **IDLE**
  - If any `*_req_valid` is high, choose a winner under the arbitration policy (see Configuration).
  - Latch the winner's addr, len and size into AR registers. Set `owner` (0 = inst, 1 = data).
  - Assert `arvalid` and go to ADDR.
- **ADDR**
  - Hold `arvalid` and the AR fields stable until `arready`.
  - On handshake, pulse the owner's `*_req_ready` in that same cycle, drop `arvalid`, and go to DATA.
- **DATA**
  - `rready` = owner's `*_resp_ready`.
  - Owner's `resp_valid` = `rvalid`; the non-owner's `resp_valid` = 0.
  - On `rvalid & rready & rlast`, go to IDLE.
- Fixed AR fields:
  - `arburst` = 2'b01 (INCR).
  - `arlock`, `arcache` and `arprot` = 0.
  - `arid` = {3'b0, owner}.
- Response routing uses the registered `owner`. `rid` is ignored. R beats seen in IDLE or ADDR are not accepted (`rready` = 0).
- Requesters must hold valid and attributes stable until ready. The arbiter samples the attributes only at grant.
- A requester that drops valid after grant does not cancel the burst. The arbiter completes the burst and delivers the beats.
- `*_resp_err` = `rresp[1]` for the owner; 0 otherwise.

## Timing
- Reset values: state IDLE; `owner` = 0; `arvalid`, `rready`, all `*_req_ready` and all `*_resp_valid` = 0; AR fields = 0, except `arburst` = 01 and `arid` = 0.
- Reset is asynchronous. Asserting it mid-burst returns the block to IDLE immediately and discards the outstanding transaction.
- Request to `arvalid`: 1 cycle, since the grant is registered in IDLE.
- `req_ready` pulses in the same cycle as the AR handshake.
- R path is combinational pass-through: 0-cycle latency from `rvalid`/`rdata` to `resp_*`.
- After the last beat there is one IDLE cycle before the next `arvalid`. Minimum request-to-request spacing is len + 3 cycles when `arready` and `rvalid` are always high.
- When both requesters are valid in the same IDLE cycle, exactly one wins. The loser stays pending with no ready pulse.

## Configuration
- `ARB_RR_EN` defined: round-robin.
  - A 1-bit `last_owner` register resets to 0, i.e. inst is treated as last served, so data wins the first tie.
  - On a tie, grant the requester that is not `last_owner`.
  - `last_owner` updates at each grant.
- `ARB_RR_EN` undefined: fixed priority, data over inst. No `last_owner` register is built.

## Test plan
- **Single inst burst:** `inst_req` with addr 0x1FC00000, len 3, `arready` = 1, 4 `rvalid` beats 0xA0–0xA3 with `rlast` on the 4th.
  - `araddr` = 0x1FC00000, `arlen` = 3, `arid` = 0.
  - `inst_req_ready` pulses once.
  - `inst_resp_data` shows 0xA0–0xA3.
  - `data_resp_valid` stays 0.
- **Simultaneous requests:** inst addr 0x100 and data addr 0x200 raised in the same cycle.
  - First AR is 0x200 with `arid` = 1.
  - After `rlast`, the next AR is 0x100.
  - This holds in both configurations, because the reset tie-break favours data.
- **Round-robin (`ARB_RR_EN`):** both requesters held valid for 4 bursts. Grants alternate D, I, D, I.
- **Fixed priority (no `ARB_RR_EN`):** same stimulus. Grants are D, D, D, D; inst is starved.
- **Backpressure:**
  - `arready` low for 5 cycles: `arvalid` and `araddr` stay stable.
  - `data_resp_ready` low for 2 cycles mid-burst: `rready` = 0 and the beat is held until accepted.
  - `rresp` = 2'b10 on beat 1: `data_resp_err` = 1 on that beat only.
- **Reset mid-burst:** deassert `aresetn` during beat 2 of len 7.
  - All outputs return to reset values asynchronously.
  - After release, a new inst request issues a fresh AR 1 cycle later.
